pipe_hazard_ctrl: RTL and testbench

Sequences the decode→execute pipeline register: decides every cycle whether the instruction in decode may advance (`stall_core_o`) and whether the fetch/decode or decode/execute latches must be flushed (`kill_*`). Sources of a stall or flush are:
- register read-after-write hazards, tracked by a per-register countdown scoreboard;
- data-memory busy;
- taken branches resolved in execute;
- TLB-miss exceptions.

It sits beside the decode stage and drives the stall/kill inputs of both pipeline latches.

---
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode/execute stall and flush sequencing with a per-register RAW countdown scoreboard
// Ports: clk_i, rst_i (async, active-high); dec_* decode instruction fields; dmem_busy_i, exe_branch_taken_i,
// exe_tlb_miss_i stall/flush sources; stall_core_o, kill_fet_dec_o, kill_dec_exe_o, exc_redirect_o, busy_o controls.
// Build option: PIPE_BYPASS_EN selects forwarding-path latencies instead of writeback latencies.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dec_valid_i,
  input  logic [4:0] dec_src_a_i,
  input  logic [4:0] dec_src_b_i,
  input  logic       dec_use_a_i,
  input  logic       dec_use_b_i,
  input  logic [4:0] dec_write_addr_i,
  input  logic       dec_int_write_enable_i,
  input  logic [1:0] dec_lat_class_i,
  input  logic       dmem_busy_i,
  input  logic       exe_branch_taken_i,
  input  logic       exe_tlb_miss_i,
  output logic       stall_core_o,
  output logic       kill_fet_dec_o,
  output logic       kill_dec_exe_o,
  output logic       exc_redirect_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {RUN, MEMW, EXC, REDIR} state_t;
`ifdef PIPE_BYPASS_EN
  localparam logic [3:0] L_ALU = 4'd0;
  localparam logic [3:0] L_LD  = 4'd1;
  localparam logic [3:0] L_MUL = 4'(MUL_LAT - 1);
`else
  localparam logic [3:0] L_ALU = 4'd3;
  localparam logic [3:0] L_LD  = 4'd3;
  localparam logic [3:0] L_MUL = 4'(MUL_LAT + 2);
`endif
  state_t     state_q, state_d;
  logic [3:0] cnt_q [32];
  logic [3:0] cnt_d [32];
  logic [3:0] lat;
  logic       hz, any_cnt, issue, stall, kfd, kde, redir;
  assign lat = dec_lat_class_i == 2'd1 ? L_LD : dec_lat_class_i == 2'd2 ? L_MUL : L_ALU;
  assign hz = dec_valid_i & ((dec_use_a_i & |cnt_q[dec_src_a_i]) | (dec_use_b_i & |cnt_q[dec_src_b_i]));
  assign issue = dec_valid_i & ~stall & ~kde & dec_int_write_enable_i & |dec_write_addr_i;
  always_comb begin
    any_cnt = 1'b0;
    for (int i = 1; i < 32; i++) any_cnt = any_cnt | (|cnt_q[i]);
  end
  // Entry 0 never loads (issue needs a nonzero address) so it stays zero from reset.
  always_comb begin
    for (int i = 0; i < 32; i++)
      cnt_d[i] = (issue && dec_write_addr_i == 5'(i)) ? lat : (|cnt_q[i] ? cnt_q[i] - 4'd1 : 4'd0);
  end
  always_comb begin
    state_d = state_q;
    stall = 1'b0;
    kfd = 1'b0;
    kde = 1'b0;
    redir = 1'b0;
    case (state_q)
      RUN: begin
        if (exe_tlb_miss_i) begin
          kfd = 1'b1;
          kde = 1'b1;
          state_d = EXC;
        end else if (exe_branch_taken_i) begin
          kfd = 1'b1;
          kde = 1'b1;
        end else if (dmem_busy_i) begin
          stall = 1'b1;
          state_d = MEMW;
        end else stall = hz;
      end
      MEMW: begin
        if (exe_tlb_miss_i) begin
          kfd = 1'b1;
          kde = 1'b1;
          state_d = EXC;
        end else if (dmem_busy_i) stall = 1'b1;
        else begin
          stall = hz;
          state_d = RUN;
        end
      end
      EXC: begin
        stall = 1'b1;
        kfd = 1'b1;
        kde = 1'b1;
        state_d = any_cnt ? EXC : REDIR;
      end
      REDIR: begin
        redir = 1'b1;
        kfd = 1'b1;
        kde = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q <= '{default: 4'd0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // Outputs are forced low for the whole time reset is held, regardless of inputs.
  assign stall_core_o = ~rst_i & stall;
  assign kill_fet_dec_o = ~rst_i & kfd;
  assign kill_dec_exe_o = ~rst_i & kde;
  assign exc_redirect_o = ~rst_i & redir;
  assign busy_o = ~rst_i & (state_q != RUN);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard-driven scenario bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int ML = 4;
`ifdef PIPE_BYPASS_EN
  localparam int LA = 0;
  localparam int LL = 1;
  localparam int LM = ML - 1;
`else
  localparam int LA = 3;
  localparam int LL = 3;
  localparam int LM = ML + 2;
`endif
  localparam logic [4:0] E_IDLE  = 5'b00000;
  localparam logic [4:0] E_STALL = 5'b10000;
  localparam logic [4:0] E_KILL  = 5'b01100;
  localparam logic [4:0] E_MEMW  = 5'b10001;
  localparam logic [4:0] E_EXC   = 5'b11101;
  localparam logic [4:0] E_REDIR = 5'b01111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v, ua, ub, we, mb, br, tl;
  logic [4:0] sa, sb, wa;
  logic [1:0] cl;
  logic stall_o, kfd_o, kde_o, redir_o, busy_o;
  logic [4:0] exp_q[$];
  int vec = 0;
  int miss = 0;
  wire [4:0] obs = {stall_o, kfd_o, kde_o, redir_o, busy_o};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MUL_LAT(ML)) dut (
    .clk_i(clk), .rst_i(rst), .dec_valid_i(v), .dec_src_a_i(sa), .dec_src_b_i(sb),
    .dec_use_a_i(ua), .dec_use_b_i(ub), .dec_write_addr_i(wa), .dec_int_write_enable_i(we),
    .dec_lat_class_i(cl), .dmem_busy_i(mb), .exe_branch_taken_i(br), .exe_tlb_miss_i(tl),
    .stall_core_o(stall_o), .kill_fet_dec_o(kfd_o), .kill_dec_exe_o(kde_o),
    .exc_redirect_o(redir_o), .busy_o(busy_o)
  );
  task automatic zero();
    v = 1'b0; ua = 1'b0; ub = 1'b0; we = 1'b0; mb = 1'b0; br = 1'b0; tl = 1'b0;
    sa = 5'd0; sb = 5'd0; wa = 5'd0; cl = 2'd0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      zero();
    end
  endtask
  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1;
    zero();
    v = 1'b1; ua = 1'b1; sa = 5'd3; mb = 1'b1; br = 1'b1; tl = 1'b1;
    @(negedge clk);
    exp_q.push_back(E_IDLE);
    e = exp_q.pop_front(); vec++;
    if (obs !== e) begin miss++; $display("FAIL reset_hold: got %b want %b", obs, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    zero();
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    e = exp_q.pop_front(); vec++;
    if (obs !== e) begin miss++; $display("FAIL reset_release: got %b want %b", obs, e); end
  endtask
  task automatic test_dep(input string nm, input logic [4:0] w, input logic [1:0] c_l,
                          input logic [4:0] r, input logic onb, input int ns);
    logic [4:0] e;
    for (int c = 0; c < ns + 3; c++) begin
      @(posedge clk); #1;
      zero();
      if (c == 0) begin v = 1'b1; wa = w; we = 1'b1; cl = c_l; end
      else if (c <= ns + 1) begin v = 1'b1; sa = r; sb = r; ua = ~onb; ub = onb; end
      exp_q.push_back((c >= 1 && c <= ns) ? E_STALL : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front(); vec++;
      if (obs !== e) begin miss++; $display("FAIL %s cyc %0d: got %b want %b", nm, c, obs, e); end
    end
    idle(16);
  endtask
  task automatic test_branch();
    logic [4:0] e;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      zero();
      if (c == 0) begin v = 1'b1; wa = 5'd3; we = 1'b1; cl = 2'd2; end
      if (c == 1 || c == 2) begin v = 1'b1; sa = 5'd3; ua = 1'b1; wa = 5'd9; we = 1'b1; cl = 2'd2; end
      if (c == 2) br = 1'b1;
      if (c == 4) begin v = 1'b1; sa = 5'd9; ua = 1'b1; end
      exp_q.push_back(c == 1 ? E_STALL : c == 2 ? E_KILL : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front(); vec++;
      if (obs !== e) begin miss++; $display("FAIL branch cyc %0d: got %b want %b", c, obs, e); end
    end
    idle(16);
  endtask
  task automatic test_tlb();
    logic [4:0] e;
    for (int c = 0; c < LM + 4; c++) begin
      @(posedge clk); #1;
      zero();
      if (c == 0) begin v = 1'b1; wa = 5'd3; we = 1'b1; cl = 2'd2; end
      if (c == 1) tl = 1'b1;
      if (c >= 2 && c <= LM + 1) begin br = 1'b1; v = 1'b1; sa = 5'd3; ua = 1'b1; end
      exp_q.push_back(c == 0 ? E_IDLE : c == 1 ? E_KILL : c <= LM + 1 ? E_EXC : c == LM + 2 ? E_REDIR : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front(); vec++;
      if (obs !== e) begin miss++; $display("FAIL tlb cyc %0d: got %b want %b", c, obs, e); end
    end
    idle(16);
  endtask
  task automatic test_memw();
    logic [4:0] e;
    for (int c = 0; c < LM + 3; c++) begin
      @(posedge clk); #1;
      zero();
      if (c == 0) begin v = 1'b1; wa = 5'd3; we = 1'b1; cl = 2'd2; end
      if (c >= 1 && c <= LM + 1) begin v = 1'b1; sa = 5'd3; ua = 1'b1; end
      if (c == 1 || c == 2) mb = 1'b1;
      exp_q.push_back(c == 0 ? E_IDLE : c == 1 ? E_STALL : c == 2 ? E_MEMW :
                      c <= LM + 1 ? {(c < LM + 1), 3'b000, (c == 3)} : E_IDLE);
      @(negedge clk);
      e = exp_q.pop_front(); vec++;
      if (obs !== e) begin miss++; $display("FAIL memw cyc %0d: got %b want %b", c, obs, e); end
    end
    idle(16);
  endtask
  task automatic test_reset_mid();
    logic [4:0] e;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      zero();
      if (c == 0) begin v = 1'b1; wa = 5'd3; we = 1'b1; cl = 2'd2; end
      else begin mb = 1'b1; v = 1'b1; sa = 5'd3; ua = 1'b1; end
      exp_q.push_back(c == 0 ? E_IDLE : c == 1 ? E_STALL : E_MEMW);
      @(negedge clk);
      e = exp_q.pop_front(); vec++;
      if (obs !== e) begin miss++; $display("FAIL rst_mid_pre cyc %0d: got %b want %b", c, obs, e); end
    end
    #1 rst = 1'b1;
    exp_q.push_back(E_IDLE);
    #1;
    e = exp_q.pop_front(); vec++;
    if (obs !== e) begin miss++; $display("FAIL rst_async: got %b want %b", obs, e); end
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    e = exp_q.pop_front(); vec++;
    if (obs !== e) begin miss++; $display("FAIL rst_held: got %b want %b", obs, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    zero();
    v = 1'b1; sa = 5'd3; ua = 1'b1;
    exp_q.push_back(E_IDLE);
    @(negedge clk);
    e = exp_q.pop_front(); vec++;
    if (obs !== e) begin miss++; $display("FAIL rst_dep: got %b want %b", obs, e); end
    idle(2);
  endtask
  initial begin
    zero();
    test_reset();
    test_dep("alu_dep", 5'd5, 2'd0, 5'd5, 1'b0, LA);
    test_dep("load_use", 5'd7, 2'd1, 5'd7, 1'b1, LL);
    test_dep("r0_write", 5'd0, 2'd1, 5'd0, 1'b0, 0);
    test_dep("mul_dep", 5'd3, 2'd2, 5'd3, 1'b0, LM);
    test_dep("mul_indep", 5'd3, 2'd2, 5'd4, 1'b0, 0);
    test_dep("class3_alu", 5'd12, 2'd3, 5'd12, 1'b1, LA);
    test_branch();
    test_tlb();
    test_memw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
